// File: rtl/alu_cmd_unit_pkg.sv
// Shared definitions for the ALU command unit: FSM state codes,
// ARM-style condition codes and flag bit positions within {N,Z,C,V}.
package alu_cmd_unit_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE    = 2'd0;
    localparam state_t ST_ISSUE   = 2'd1;
    localparam state_t ST_CAPTURE = 2'd2;
    localparam state_t ST_RESP    = 2'd3;

    localparam logic [3:0] CC_EQ = 4'b0000;
    localparam logic [3:0] CC_NE = 4'b0001;
    localparam logic [3:0] CC_CS = 4'b0010;
    localparam logic [3:0] CC_CC = 4'b0011;
    localparam logic [3:0] CC_MI = 4'b0100;
    localparam logic [3:0] CC_PL = 4'b0101;
    localparam logic [3:0] CC_VS = 4'b0110;
    localparam logic [3:0] CC_VC = 4'b0111;
    localparam logic [3:0] CC_HI = 4'b1000;
    localparam logic [3:0] CC_LS = 4'b1001;
    localparam logic [3:0] CC_GE = 4'b1010;
    localparam logic [3:0] CC_LT = 4'b1011;
    localparam logic [3:0] CC_GT = 4'b1100;
    localparam logic [3:0] CC_LE = 4'b1101;
    localparam logic [3:0] CC_AL = 4'b1110;
    localparam logic [3:0] CC_NV = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

endpackage

// File: rtl/alu_cmd_unit_cond.sv
// cond_check: combinational ARM condition evaluation.
// Ports: cond (4-bit code), flags ({N,Z,C,V}) -> pass.
module cond_check
    import alu_cmd_unit_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       pass
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        pass = 1'b0;
        unique case (cond)
            CC_EQ: pass = z;
            CC_NE: pass = !z;
            CC_CS: pass = c;
            CC_CC: pass = !c;
            CC_MI: pass = n;
            CC_PL: pass = !n;
            CC_VS: pass = v;
            CC_VC: pass = !v;
            CC_HI: pass = c && !z;
            CC_LS: pass = !c || z;
            CC_GE: pass = (n == v);
            CC_LT: pass = (n != v);
            CC_GT: pass = !z && (n == v);
            CC_LE: pass = z || (n != v);
            CC_AL: pass = 1'b1;
            CC_NV: pass = 1'b0;
            default: pass = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_cmd_unit.sv
// alu_cmd_unit: sequences one command through an external ALU.
// Ports: in_* command handshake, alu_* ALU link, out_* response, flags_q.
module alu_cmd_unit
    import alu_cmd_unit_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in_a,
    input  logic [N-1:0] in_b,
    input  logic [2:0]   in_cntr,
    input  logic [3:0]   in_cond,
    input  logic         in_setflags,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [2:0]   alu_cntr,
    input  logic [N-1:0] alu_r,
    input  logic [3:0]   alu_flags,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_r,
    output logic [3:0]   out_flags,
    output logic         out_exec,
    output logic [3:0]   flags_q
);

    state_t     state, state_nx;
    logic [3:0] cond_q;
    logic       setflags_q;
    logic       pass;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_RESP);

    // flags_q cannot change between accept and the CAPTURE edge, so
    // evaluating here is the same as evaluating at accept time.
    cond_check u_cond (
        .cond  (cond_q),
        .flags (flags_q),
        .pass  (pass)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE:    if (in_valid) state_nx = ST_ISSUE;
            ST_ISSUE:   state_nx = ST_CAPTURE;
            ST_CAPTURE: state_nx = ST_RESP;
            ST_RESP:    if (out_ready) state_nx = ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cntr   <= '0;
            cond_q     <= '0;
            setflags_q <= 1'b0;
            out_r      <= '0;
            out_flags  <= '0;
            out_exec   <= 1'b0;
            flags_q    <= '0;
        end else begin
            state <= state_nx;
            if (in_ready && in_valid) begin
                alu_a      <= in_a;
                alu_b      <= in_b;
                alu_cntr   <= in_cntr;
                cond_q     <= in_cond;
                setflags_q <= in_setflags;
            end
            if (state == ST_CAPTURE) begin
                out_r     <= alu_r;
                out_flags <= alu_flags;
                out_exec  <= pass;
                if (setflags_q && pass)
                    flags_q <= alu_flags;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_unit.sv
// Self-checking bench for alu_cmd_unit with a small behavioural ALU.
// Directed vector table plus stall and mid-operation reset sequences.
module tb_alu_cmd_unit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_cntr = '0;
    logic [3:0] in_cond = '0;
    logic       in_setflags = 1'b0;
    logic [7:0] alu_a, alu_b;
    logic [2:0] alu_cntr;
    logic [7:0] alu_r;
    logic [3:0] alu_flags;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_r;
    logic [3:0] out_flags;
    logic       out_exec;
    logic [3:0] flags_q;

    int checks = 0;
    int errors = 0;

    alu_cmd_unit #(.N(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_cntr     (in_cntr),
        .in_cond     (in_cond),
        .in_setflags (in_setflags),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_cntr    (alu_cntr),
        .alu_r       (alu_r),
        .alu_flags   (alu_flags),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_r       (out_r),
        .out_flags   (out_flags),
        .out_exec    (out_exec),
        .flags_q     (flags_q)
    );

    always #5 clk = ~clk;

    // ALU: 000 add, 001 sub (C = no borrow), 010 and, 011 or, 100 xor
    logic [8:0] sum9;
    always_comb begin
        sum9 = 9'd0;
        alu_r = 8'd0;
        alu_flags = 4'd0;
        case (alu_cntr)
            3'b000: begin
                sum9 = {1'b0, alu_a} + {1'b0, alu_b};
                alu_r = sum9[7:0];
                alu_flags[1] = sum9[8];
                alu_flags[0] = (alu_a[7] == alu_b[7]) && (alu_r[7] != alu_a[7]);
            end
            3'b001: begin
                alu_r = alu_a - alu_b;
                alu_flags[1] = (alu_a >= alu_b);
                alu_flags[0] = (alu_a[7] != alu_b[7]) && (alu_r[7] != alu_a[7]);
            end
            3'b010: alu_r = alu_a & alu_b;
            3'b011: alu_r = alu_a | alu_b;
            3'b100: alu_r = alu_a ^ alu_b;
            default: alu_r = alu_a;
        endcase
        alu_flags[3] = alu_r[7];
        alu_flags[2] = (alu_r == 8'd0);
    end

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] cntr;
        logic [3:0] cond;
        logic       sf;
        logic [7:0] r;
        logic [3:0] fl;
        logic       ex;
        logic [3:0] fq;
    } vec_t;

    vec_t vecs[17];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_cmd(input vec_t v, input int idx);
        string t;
        t = $sformatf("v%0d", idx);
        in_a = v.a;
        in_b = v.b;
        in_cntr = v.cntr;
        in_cond = v.cond;
        in_setflags = v.sf;
        in_valid = 1'b1;
        chk({t, " in_ready"}, int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk({t, " alu_a"}, int'(alu_a), int'(v.a));
        chk({t, " alu_b"}, int'(alu_b), int'(v.b));
        chk({t, " alu_cntr"}, int'(alu_cntr), int'(v.cntr));
        chk({t, " ov issue"}, int'(out_valid), 0);
        step();
        chk({t, " ov capture"}, int'(out_valid), 0);
        step();
        chk({t, " ov resp"}, int'(out_valid), 1);
        chk({t, " out_r"}, int'(out_r), int'(v.r));
        chk({t, " out_flags"}, int'(out_flags), int'(v.fl));
        chk({t, " out_exec"}, int'(out_exec), int'(v.ex));
        chk({t, " flags_q"}, int'(flags_q), int'(v.fq));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({t, " ov done"}, int'(out_valid), 0);
        chk({t, " rdy done"}, int'(in_ready), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        //            a      b      op    cond    sf    r      fl       ex    fq
        vecs[0]  = '{8'd15, 8'd10, 3'd0, 4'b1110, 1'b1, 8'd25, 4'b0000, 1'b1, 4'b0000};
        vecs[1]  = '{8'd15, 8'd15, 3'd1, 4'b1110, 1'b1, 8'd0,  4'b0110, 1'b1, 4'b0110};
        vecs[2]  = '{8'd1,  8'd1,  3'd0, 4'b0001, 1'b1, 8'd2,  4'b0000, 1'b0, 4'b0110};
        vecs[3]  = '{8'd1,  8'd1,  3'd0, 4'b0000, 1'b1, 8'd2,  4'b0000, 1'b1, 4'b0000};
        vecs[4]  = '{8'h88, 8'd88, 3'd1, 4'b1110, 1'b1, 8'd48, 4'b0011, 1'b1, 4'b0011};
        vecs[5]  = '{8'd3,  8'd4,  3'd0, 4'b0110, 1'b0, 8'd7,  4'b0000, 1'b1, 4'b0011};
        vecs[6]  = '{8'h7f, 8'd1,  3'd0, 4'b1111, 1'b1, 8'h80, 4'b1001, 1'b0, 4'b0011};
        vecs[7]  = '{8'd5,  8'd5,  3'd2, 4'b1010, 1'b1, 8'd5,  4'b0000, 1'b0, 4'b0011};
        vecs[8]  = '{8'd5,  8'd5,  3'd2, 4'b1011, 1'b1, 8'd5,  4'b0000, 1'b1, 4'b0000};
        vecs[9]  = '{8'hf0, 8'h0f, 3'd3, 4'b1000, 1'b1, 8'hff, 4'b1000, 1'b0, 4'b0000};
        vecs[10] = '{8'h80, 8'h80, 3'd0, 4'b1001, 1'b1, 8'h00, 4'b0111, 1'b1, 4'b0111};
        vecs[11] = '{8'd2,  8'd1,  3'd1, 4'b1100, 1'b1, 8'd1,  4'b0010, 1'b0, 4'b0111};
        vecs[12] = '{8'd2,  8'd1,  3'd1, 4'b1101, 1'b1, 8'd1,  4'b0010, 1'b1, 4'b0010};
        vecs[13] = '{8'd0,  8'd1,  3'd1, 4'b0011, 1'b0, 8'hff, 4'b1000, 1'b0, 4'b0010};
        vecs[14] = '{8'd0,  8'd1,  3'd1, 4'b0010, 1'b1, 8'hff, 4'b1000, 1'b1, 4'b1000};
        vecs[15] = '{8'd1,  8'd2,  3'd4, 4'b0100, 1'b0, 8'd3,  4'b0000, 1'b1, 4'b1000};
        vecs[16] = '{8'd1,  8'd2,  3'd4, 4'b0101, 1'b0, 8'd3,  4'b0000, 1'b0, 4'b1000};

        #2;
        chk("rst out_valid", int'(out_valid), 0);
        chk("rst out_r", int'(out_r), 0);
        chk("rst out_flags", int'(out_flags), 0);
        chk("rst out_exec", int'(out_exec), 0);
        chk("rst flags_q", int'(flags_q), 0);
        chk("rst alu_a", int'(alu_a), 0);
        chk("rst alu_b", int'(alu_b), 0);
        chk("rst alu_cntr", int'(alu_cntr), 0);
        step();
        step();
        rst_n = 1'b1;
        chk("rst in_ready", int'(in_ready), 1);

        for (int i = 0; i < 17; i++)
            run_cmd(vecs[i], i);

        // Stall in RESP with in_valid noise, then simultaneous
        // out_ready and in_valid: command must wait for IDLE.
        in_a = 8'd9;
        in_b = 8'd4;
        in_cntr = 3'd0;
        in_cond = 4'b1110;
        in_setflags = 1'b0;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        step();
        for (int k = 0; k < 5; k++) begin
            in_valid = k[0];
            in_a = 8'h55;
            in_b = 8'h01;
            chk("stall out_valid", int'(out_valid), 1);
            chk("stall out_r", int'(out_r), 13);
            chk("stall out_flags", int'(out_flags), 0);
            chk("stall out_exec", int'(out_exec), 1);
            chk("stall in_ready", int'(in_ready), 0);
            chk("stall alu_a", int'(alu_a), 9);
            step();
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("same-cycle not taken", int'(alu_a), 9);
        chk("same-cycle idle", int'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("next accept alu_a", int'(alu_a), 8'h55);
        step();
        step();
        chk("next resp valid", int'(out_valid), 1);
        chk("next resp r", int'(out_r), 8'h56);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Reset while in CAPTURE: no response, flags cleared.
        in_a = 8'd15;
        in_b = 8'd15;
        in_cntr = 3'd1;
        in_cond = 4'b1110;
        in_setflags = 1'b1;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", int'(out_valid), 0);
        chk("midrst flags_q", int'(flags_q), 0);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            chk("postrst out_valid", int'(out_valid), 0);
            chk("postrst flags_q", int'(flags_q), 0);
            chk("postrst in_ready", int'(in_ready), 1);
        end
        run_cmd('{8'd1, 8'd2, 3'd0, 4'b0000, 1'b1, 8'd3, 4'b0000, 1'b0, 4'b0000}, 99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_cmd_unit.md
ALU_CMD_UNIT -- requirements
Module: alu_cmd_unit

Interface
REQ-001 Parameter: N, default 8, operand/result width in bits (two's complement).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 in_valid  in  1  command present.
REQ-005 in_ready  out  1  unit can accept a command.
REQ-006 in_a, in_b  in  N each  signed operands.
REQ-007 in_cntr  in  3  ALU operation select, passed through unmodified.
REQ-008 in_cond  in  4  condition code gating execution.
REQ-009 in_setflags  in  1  update flag register when command executes.
REQ-010 alu_a, alu_b  out  N each  registered operands to the combinational ALU.
REQ-011 alu_cntr  out  3  registered operation select to the ALU.
REQ-012 alu_r  in  N  ALU result; alu_flags  in  4  ALU flags {N,Z,C,V}, bit 3 = N.
REQ-013 out_valid  in/out: out  1  response present; out_ready  in  1  consumer accepts.
REQ-014 out_r  out  N  captured result; out_flags  out  4  flags captured from ALU.
REQ-015 out_exec  out  1  condition passed; flags_q  out  4  architectural flag register {N,Z,C,V}.

Function
REQ-016 FSM states IDLE, ISSUE, CAPTURE, RESP; IDLE -> ISSUE on in_valid&&in_ready; ISSUE -> CAPTURE unconditionally; CAPTURE -> RESP unconditionally; RESP -> IDLE on out_ready.
REQ-017 in_ready SHALL be 1 only in IDLE; command fields latched on accepting edge.
REQ-018 alu_a/alu_b/alu_cntr SHALL hold latched values from ISSUE through RESP and hold last values in IDLE.
REQ-019 ISSUE is a one-cycle settle cycle; alu_r/alu_flags SHALL be sampled on the edge leaving CAPTURE.
REQ-020 Latency: accept edge to out_valid asserted = 3 cycles; throughput one command per 4 cycles minimum.
REQ-021 out_valid SHALL be 1 exactly in RESP; out_r, out_flags, out_exec SHALL stay stable while out_valid && !out_ready.
REQ-022 out_exec SHALL be evaluated against flags_q as it stood at accept time, ARM encoding: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 NV 0.
REQ-023 flags_q SHALL load alu_flags on the CAPTURE edge iff in_setflags && out_exec; otherwise unchanged.
REQ-024 out_r and out_flags SHALL carry ALU values regardless of out_exec; consumer discards when out_exec=0.
REQ-025 in_valid in non-IDLE states SHALL be ignored (no queueing); command changes while not ready have no effect.
REQ-026 Simultaneous out_ready in RESP and in_valid: command NOT accepted that cycle (in_ready=0 in RESP); accepted in following IDLE.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, in_ready=1 after release, out_valid=0, out_r=0, out_flags=0, out_exec=0, flags_q=0000, alu_a=alu_b=0, alu_cntr=000.
REQ-028 Reset mid-operation (any state) SHALL abandon the command with no response and no flag update.
REQ-029 First accept possible on first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package SHALL hold the state enum, the 4-bit condition-code constants, and flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0).
REQ-031 Condition evaluation SHALL be a separate combinational sub-module cond_check (inputs cond, flags; output pass).
REQ-032 The ALU is external; the unit contains no arithmetic.

Verification (bench instantiates the ALU as alu_r/alu_flags source, N=8)
REQ-033 Reset then A=15,B=10,cntr=000,cond=1110,setflags=1 -> out_valid 3 cycles after accept, out_r=25, out_flags=0000, out_exec=1, flags_q=0000.
REQ-034 A=15,B=15,cntr=001,cond=1110,setflags=1, then A=1,B=1,cond=0000 -> second out_exec=1 (Z set by first); with cond=0001 -> out_exec=0, flags_q unchanged.
REQ-035 A=-120,B=88,cntr=001,setflags=1,cond=1110 -> R=-208 wraps to 48, V=1, flags_q.V=1; next cond=0110 -> out_exec=1.
REQ-036 out_ready held 0 for 5 cycles in RESP -> out_r/out_flags/out_exec stable, in_ready=0, in_valid pulses ignored.
REQ-037 rst_n pulsed low during CAPTURE -> out_valid never asserts for that command, flags_q=0000, in_ready=1 after release.
REQ-038 cond=1111 with setflags=1 -> out_exec=0, flags_q unchanged.
